// File: rtl/sm_dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths,
// and the wait-state counter limits.
package sm_dmem_pkg;

  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sm_dmem_array.sv
// Word-addressed RAM: one byte-enabled read-before-write port for the FSM and
// one independent read port for debug. Both reads are registered (1 cycle).
module sm_dmem_array
  import sm_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [BE_W-1:0]       i_be,
  output logic [DATA_W-1:0]     o_rdata,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  output logic [DATA_W-1:0]     o_dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_dbg_data;

  // Storage itself is never reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= '0;
      r_dbg_data <= '0;
    end else begin
      if (i_en) begin
        r_rdata <= r_mem[i_addr];
      end
      r_dbg_data <= r_mem[i_dbg_addr];
    end
  end

  assign o_rdata    = r_rdata;
  assign o_dbg_data = r_dbg_data;

endmodule

// File: rtl/sm_dmem_responder.sv
// Load/store responder with programmable wait states between request accept
// and response; memory access commits on the edge that enters RESP.
module sm_dmem_responder
  import sm_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [BE_W-1:0]       req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam logic [CNT_W-1:0] LP_CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [BE_W-1:0]       r_be;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_cmd_write;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [DATA_W-1:0]     w_cmd_wdata;
  logic [BE_W-1:0]       w_cmd_be;
  logic [DATA_W-1:0]     w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Zero-wait commits happen on the accept edge, before the latches hold the request.
  assign w_cmd_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_cmd_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_cmd_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_cmd_be    = (r_state == ST_IDLE) ? req_be    : r_be;

  sm_dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_commit),
    .i_we       (w_cmd_write),
    .i_addr     (w_cmd_addr),
    .i_wdata    (w_cmd_wdata),
    .i_be       (w_cmd_be),
    .o_rdata    (w_rdata),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Store responses read as zero; the latched write flag holds until the next accept.
  assign rsp_rdata = r_write ? '0 : w_rdata;

endmodule

// File: tb/tb_sm_dmem_responder.sv
// Bench for sm_dmem_responder: three instances (wait states 1, 0, 3), scoreboard
// of expected responses against a word-array memory model.
module tb_sm_dmem_responder;

  localparam int AW   = 6;
  localparam int NDUT = 3;

  logic        clk;
  logic        rst       [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_write [NDUT];
  logic [5:0]  req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic [5:0]  dbg_addr  [NDUT];
  logic [31:0] dbg_data  [NDUT];

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      sm_dmem_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) u_dut (
        .clk       (clk),
        .rst       (rst[g]),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .req_write (req_write[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .req_be    (req_be[g]),
        .rsp_valid (rsp_valid[g]),
        .rsp_ready (rsp_ready[g]),
        .rsp_rdata (rsp_rdata[g]),
        .dbg_addr  (dbg_addr[g]),
        .dbg_data  (dbg_data[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [NDUT][64];

  typedef struct {
    int          k;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q [$];

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic issue_model(input int k, input bit wr, input logic [5:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    e.k = k;
    e.d = wr ? 32'h0 : model[k][a];
    exp_q.push_back(e);
    if (wr) model[k][a] = merge(model[k][a], d, be);
  endtask

  task automatic drive(input int k, input bit wr, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
  endtask

  // Called and returns just after a falling edge, with the DUT idle.
  task automatic do_req(input int k, input bit wr, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    int lat;
    issue_model(k, wr, a, d, be);
    drive(k, wr, a, d, be);
    rsp_ready[k] = 1'b1;
    check($sformatf("req_ready_idle%0d", k), 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency%0d", k), 32'(lat), 32'(wc(k) + 1));
    @(negedge clk);
    check($sformatf("back_to_idle%0d", k), {30'd0, rsp_valid[k], req_ready[k]}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < NDUT; k++) begin
        if (rst[k] === 1'b0) begin
          if (req_ready[k] === 1'b1 && rsp_valid[k] === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL mutex%0d: req_ready and rsp_valid both 1, required exclusive", k);
          end
          if (rsp_valid[k] === 1'b1 && rsp_ready[k] === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_rsp%0d: got %h, required no response", k, rsp_rdata[k]);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rsp_tag%0d", k), 32'(k), 32'(e.k));
              check($sformatf("rsp_rdata%0d", k), rsp_rdata[k], e.d);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_val;
    int          wait_n;
    logic [5:0]  ra;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0; dbg_addr[k] = '0;
    end

    // Asynchronous reset between clock edges.
    #2;
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_req_ready%0d", k), 32'(req_ready[k]), 32'd1);
      check($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
      check($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k], 32'd0);
      check($sformatf("rst_dbg_data%0d", k), dbg_data[k], 32'd0);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
    @(negedge clk);

    // Fill every word with a known value so the model matches the array.
    for (int k = 0; k < NDUT; k++)
      for (int a = 0; a < 64; a++)
        do_req(k, 1'b1, 6'(a), $urandom, 4'hF);

    // Store/load and byte-enable cases on the one-wait-state instance.
    do_req(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    do_req(0, 1'b0, 6'd5, 32'h0, 4'h0);
    do_req(0, 1'b1, 6'd3, 32'h11223344, 4'hF);
    do_req(0, 1'b1, 6'd3, 32'hAABBCCDD, 4'b0101);
    do_req(0, 1'b0, 6'd3, 32'h0, 4'h0);
    do_req(0, 1'b1, 6'd3, 32'hFFFFFFFF, 4'b0000);
    do_req(0, 1'b0, 6'd3, 32'h0, 4'h0);

    // Debug read colliding with a store commit.
    do_req(0, 1'b1, 6'd9, 32'h00000001, 4'hF);
    dbg_addr[0] = 6'd9;
    issue_model(0, 1'b1, 6'd9, 32'h00000007, 4'hF);
    drive(0, 1'b1, 6'd9, 32'h00000007, 4'hF);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("dbg_pre", dbg_data[0], 32'h1);
    @(negedge clk);
    check("dbg_commit_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("dbg_collide", dbg_data[0], 32'h1);
    @(negedge clk);
    check("dbg_post", dbg_data[0], 32'h7);

    // Backpressure on the zero-wait instance, with a second request held during RESP.
    hold_val = model[1][12];
    issue_model(1, 1'b0, 6'd12, 32'h0, 4'h0);
    drive(1, 1'b0, 6'd12, 32'h0, 4'h0);
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    issue_model(1, 1'b1, 6'd12, 32'h5A5A5A5A, 4'hF);
    drive(1, 1'b1, 6'd12, 32'h5A5A5A5A, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid[1]), 32'd1);
      check("bp_req_ready", 32'(req_ready[1]), 32'd0);
      check("bp_rsp_rdata", rsp_rdata[1], hold_val);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {30'd0, rsp_valid[1], req_ready[1]}, 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("bp_second_rsp", 32'(rsp_valid[1]), 32'd1);
    @(negedge clk);
    check("bp_second_done", {30'd0, rsp_valid[1], req_ready[1]}, 32'd1);
    do_req(1, 1'b0, 6'd12, 32'h0, 4'h0);

    // Reset while a store sits in WAIT on the three-wait-state instance.
    drive(2, 1'b1, 6'd2, 32'hBAD0BAD0, 4'hF);
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("midop_wait", {30'd0, rsp_valid[2], req_ready[2]}, 32'd0);
    #1;
    rst[2] = 1'b1;
    #1;
    check("midop_rst_req_ready", 32'(req_ready[2]), 32'd1);
    check("midop_rst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    @(negedge clk);
    do_req(2, 1'b0, 6'd2, 32'h0, 4'h0);

    // Randomized traffic plus idle-time debug reads.
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 25; i++) begin
        do_req(k, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
               4'($urandom_range(0, 15)));
        ra = 6'($urandom_range(0, 63));
        dbg_addr[k] = ra;
        @(negedge clk);
        check($sformatf("dbg_rand%0d", k), dbg_data[k], model[k][ra]);
      end
    end

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_dmem_responder.md
Name: sm_dmem_responder

Overview:
- Data-memory responder serving the CPU core's load/store port through a valid/ready request/response handshake.
- Programmable wait states; byte-enabled writes.
- Independent registered debug read port for board display.
- Word-addressed, matching the core's word-indexed address scheme; sits between the core's data-bus initiator and the on-chip RAM array.

Parameters:
- ADDR_WIDTH, 6, word address width; depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 1, extra cycles between request accept and response valid; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for store; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data; 0 for store responses.
- dbg_addr  in  ADDR_WIDTH  debug read address.
- dbg_data  out  32  debug read data, registered.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, dbg_data=0, wait counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch write, addr, wdata and be.
  - If WAIT_CYCLES==0, go to RESP; otherwise load counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At count 0, go to RESP.
- Commit on the IDLE→RESP or WAIT→RESP transition edge:
  - Load: rsp_rdata <= mem[addr].
  - Store: write mem[addr] bytes where be=1; rsp_rdata <= 0.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata stays stable until the handshake.
  - On rsp_ready, go to IDLE and clear rsp_valid next edge.
  - rsp_ready low stalls indefinitely with no state change.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
- Throughput: no request is accepted in the same cycle as the response handshake. Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
- req_valid in non-IDLE states is ignored; the initiator must hold it until it sees req_ready.
- req_ready and rsp_valid are mutually exclusive at all times.
- Store with be=4'b0000: memory unchanged; a response is still issued.
- Addressing: addresses are fully decoded, so there is no out-of-range case. Counter width is 4 bits.
- Debug port:
  - dbg_data <= mem[dbg_addr] every cycle, 1-cycle latency.
  - Independent of the FSM.
  - If it collides with a store commit to the same address in the same edge, it returns the pre-write value (read-before-write).
- Reset mid-operation: an uncommitted latched store is discarded; a committed store remains in memory. FSM returns to IDLE immediately.

Decomposition:
- Shared package sm_dmem_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Data width 32.
  - Byte-enable width 4.
  - Max WAIT_CYCLES constant 15.
- Sub-module sm_dmem_array:
  - 2**ADDR_WIDTH x 32 storage.
  - One synchronous byte-enabled read/write port (read-before-write) for the FSM.
  - One synchronous read port for debug.

Test Plan:
- Reset then idle: rst pulse mid-cycle (asynchronous) → req_ready=1, rsp_valid=0, rsp_rdata=0, dbg_data=0 immediately.
- Store/load, WAIT_CYCLES=1:
  - Store addr 5, 0xDEADBEEF, be=F → rsp_valid on 2nd edge after accept, rsp_rdata=0.
  - Load addr 5 → rsp_rdata=0xDEADBEEF, 2-cycle latency.
- Byte enables: mem[3]=0x11223344, then store 0xAABBCCDD with be=4'b0101 → load returns 0x11BB33DD.
- Backpressure, WAIT_CYCLES=0: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, second req_valid ignored. Release → IDLE next edge, then accept.
- Debug collision: store 0x00000007 to addr 9 (old 0x1) with dbg_addr=9 at the commit edge → dbg_data=0x1 that cycle, 0x7 the next.
- Reset mid-op, WAIT_CYCLES=3: accept store to addr 2, assert rst during WAIT → mem[2] unchanged on later load, FSM in IDLE, rsp_valid=0.
